// File: rtl/cache_mem_bridge.sv
// Block-to-word bridge between the cache mem_* port and a req/ack memory bus.
// Define CRITICAL_WORD_FIRST_EN to start fills at the requested word and emit a critical-word pulse.
module cache_mem_bridge #(
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int BLK_WIDTH = 128,
  parameter int BYTE      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_rd_en,
  input  logic                 mem_wr_en,
  input  logic [PA_WIDTH-1:0]  mem_rd_addr,
  input  logic [PA_WIDTH-1:0]  mem_wr_addr,
  input  logic [BLK_WIDTH-1:0] mem_wr_blk,
  output logic [BLK_WIDTH-1:0] mem_rd_blk,
  output logic                 mem_done,
  output logic                 mem_busy,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [PA_WIDTH-1:0]  bus_addr,
  output logic [WRD_WIDTH-1:0] bus_wdata,
  input  logic [WRD_WIDTH-1:0] bus_rdata,
  input  logic                 bus_ack,
  output logic                 crit_valid,
  output logic [WRD_WIDTH-1:0] crit_word
);

  localparam int NBEATS = BLK_WIDTH / WRD_WIDTH;
  localparam int BEAT_W = $clog2(NBEATS);
  localparam int WO_W   = $clog2(WRD_WIDTH / BYTE);
  localparam int BOFF   = $clog2(BLK_WIDTH / BYTE);
  localparam int HI_W   = PA_WIDTH - BOFF;
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(NBEATS - 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, DONE} state_e;

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [BEAT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]    start_q, start_d;
  logic                 rd_en_q, rd_en_d;
  logic [HI_W-1:0]      rd_hi_q, rd_hi_d;
  logic [HI_W-1:0]      wr_hi_q, wr_hi_d;
  logic [BLK_WIDTH-1:0] wr_blk_q, wr_blk_d;
  logic [BLK_WIDTH-1:0] buf_q, buf_d;
  logic [BLK_WIDTH-1:0] rd_blk_q, rd_blk_d;
  logic [BEAT_W-1:0]    rd_start;
  logic                 ack;
  logic                 unused_ok;

  // Sub-block address bits only select the starting word (if at all).
  assign unused_ok = ^{mem_rd_addr[BOFF-1:0], mem_wr_addr[BOFF-1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
  logic                 crit_valid_q, crit_valid_d;
  logic [WRD_WIDTH-1:0] crit_word_q, crit_word_d;
  assign rd_start   = mem_rd_addr[WO_W +: BEAT_W];
  assign crit_valid = crit_valid_q;
  assign crit_word  = crit_word_q;
`else
  assign rd_start   = '0;
  assign crit_valid = 1'b0;
  assign crit_word  = '0;
`endif

  assign bus_req    = (state_q == WR_BURST) || (state_q == RD_BURST);
  assign bus_we     = (state_q == WR_BURST);
  assign mem_done   = (state_q == DONE);
  assign mem_busy   = (state_q != IDLE);
  assign mem_rd_blk = rd_blk_q;
  assign ack        = bus_req & bus_ack;

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      WR_BURST: begin
        bus_addr  = {wr_hi_q, beat_q, {WO_W{1'b0}}};
        bus_wdata = wr_blk_q[int'(beat_q)*WRD_WIDTH +: WRD_WIDTH];
      end
      RD_BURST: bus_addr = {rd_hi_q, beat_q, {WO_W{1'b0}}};
      default: ;
    endcase
  end

  // beat_q addresses the word; cnt_q counts completed beats so a wrapped fill still ends after NBEATS.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    rd_en_d  = rd_en_q;
    rd_hi_d  = rd_hi_q;
    wr_hi_d  = wr_hi_q;
    wr_blk_d = wr_blk_q;
    buf_d    = buf_q;
    rd_blk_d = rd_blk_q;
`ifdef CRITICAL_WORD_FIRST_EN
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_rd_en || mem_wr_en) begin
          rd_en_d  = mem_rd_en;
          rd_hi_d  = mem_rd_addr[PA_WIDTH-1:BOFF];
          wr_hi_d  = mem_wr_addr[PA_WIDTH-1:BOFF];
          wr_blk_d = mem_wr_blk;
          start_d  = rd_start;
          cnt_d    = '0;
          state_d  = mem_wr_en ? WR_BURST : RD_BURST;
          beat_d   = mem_wr_en ? '0 : rd_start;
        end
      end
      WR_BURST: begin
        if (ack) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = rd_en_q ? RD_BURST : DONE;
            beat_d  = rd_en_q ? start_q : '0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RD_BURST: begin
        if (ack) begin
          buf_d[int'(beat_q)*WRD_WIDTH +: WRD_WIDTH] = bus_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
          if (cnt_q == '0) begin
            crit_valid_d = 1'b1;
            crit_word_d  = bus_rdata;
          end
`endif
          if (cnt_q == LAST) begin
            rd_blk_d = buf_d;
            cnt_d    = '0;
            beat_d   = '0;
            state_d  = DONE;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      cnt_q    <= '0;
      start_q  <= '0;
      rd_en_q  <= 1'b0;
      rd_hi_q  <= '0;
      wr_hi_q  <= '0;
      wr_blk_q <= '0;
      buf_q    <= '0;
      rd_blk_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      rd_en_q  <= rd_en_d;
      rd_hi_q  <= rd_hi_d;
      wr_hi_q  <= wr_hi_d;
      wr_blk_q <= wr_blk_d;
      buf_q    <= buf_d;
      rd_blk_q <= rd_blk_d;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed self-checking bench for cache_mem_bridge; memory returns 0xA0 + word index.
module tb_cache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_rd_en, mem_wr_en;
  logic [31:0]  mem_rd_addr, mem_wr_addr;
  logic [127:0] mem_wr_blk, mem_rd_blk;
  logic         mem_done, mem_busy;
  logic         bus_req, bus_we, bus_ack;
  logic [31:0]  bus_addr, bus_wdata, bus_rdata;
  logic         crit_valid;
  logic [31:0]  crit_word;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_wd[$];
  logic        q_we[$];

  localparam logic [127:0] ABLK = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] EVB  = 128'h00000044_00000033_00000022_00000011;

  always #5 clk = ~clk;

  assign bus_rdata = 32'hA0 + 32'(bus_addr[3:2]);

  cache_mem_bridge #(.PA_WIDTH(32), .WRD_WIDTH(32), .BLK_WIDTH(128), .BYTE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk),
    .mem_done(mem_done), .mem_busy(mem_busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .crit_valid(crit_valid), .crit_word(crit_word)
  );

  always @(posedge clk) begin
    if (bus_req && bus_ack) begin
      q_addr.push_back(bus_addr);
      q_wd.push_back(bus_wdata);
      q_we.push_back(bus_we);
    end
    if (mem_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_wd.delete();
    q_we.delete();
    done_cnt = 0;
  endtask

  // Issue a request at the next edge; returns at the negedge after that edge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] ra,
                       input logic [31:0] wa, input logic [127:0] blk);
    mem_rd_en = rd; mem_wr_en = wr; mem_rd_addr = ra; mem_wr_addr = wa; mem_wr_blk = blk;
    cyc();
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
  endtask

  // Runs until mem_done; per>1 acks every per-th cycle and checks hold/busy while waiting.
  task automatic wait_done(input string tag, input int maxc, input int per);
    bit seen = 0;
    logic [31:0] pa, pw;
    logic pv, pack;
    for (int c = 0; c < maxc && !seen; c++) begin
      pa = bus_addr; pw = bus_wdata; pv = bus_req;
      pack = (per <= 1) ? 1'b1 : ((c % per) == per - 1);
      bus_ack = pack;
      cyc();
      if (mem_done) seen = 1;
      else if (per > 1) begin
        chk({tag, " busy"}, 128'(mem_busy), 128'd1);
        if (pv && !pack && bus_req) begin
          chk({tag, " addr_hold"}, 128'(bus_addr), 128'(pa));
          chk({tag, " wdata_hold"}, 128'(bus_wdata), 128'(pw));
        end
      end
    end
    bus_ack = 1'b1;
    chk({tag, " done_seen"}, 128'(seen), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_rd_en = 0; mem_wr_en = 0; mem_rd_addr = '0; mem_wr_addr = '0;
    mem_wr_blk = '0; bus_ack = 1'b1;
    cyc(); cyc();
    chk("rst bus_req", 128'(bus_req), 0);
    chk("rst busy", 128'(mem_busy), 0);
    chk("rst done", 128'(mem_done), 0);
    chk("rst rd_blk", mem_rd_blk, 0);
    chk("rst bus_addr", 128'(bus_addr), 0);
    chk("rst crit_valid", 128'(crit_valid), 0);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("idle ack ignored", 128'(q_addr.size()), 0);

    // Read only, zero wait, cycle-exact.
    clear_log();
    issue(1, 0, 32'h0000_1234, 32'h0, '0);
    chk("rd busy", 128'(mem_busy), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd addr%0d", i), 128'(bus_addr), 128'(32'h1230 + 32'(4 * i)));
      chk($sformatf("rd we%0d", i), 128'(bus_we), 0);
      chk($sformatf("rd nodone%0d", i), 128'(mem_done), 0);
      cyc();
    end
    chk("rd done E4", 128'(mem_done), 1);
    chk("rd req low", 128'(bus_req), 0);
    chk("rd blk", mem_rd_blk, ABLK);
    cyc();
    chk("rd done drop", 128'(mem_done), 0);
    chk("rd busy drop", 128'(mem_busy), 0);
    chk("rd beats", 128'(q_addr.size()), 4);
    chk("rd done_cnt", 128'(done_cnt), 1);

    // Eviction: writeback then fill.
    clear_log();
    issue(1, 1, 32'h0000_3008, 32'h0000_2000, EVB);
    wait_done("ev", 30, 1);
    cyc();
    chk("ev beats", 128'(q_addr.size()), 8);
    if (q_addr.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ev waddr%0d", i), 128'(q_addr[i]), 128'(32'h2000 + 32'(4 * i)));
        chk($sformatf("ev we%0d", i), 128'(q_we[i]), 1);
        chk($sformatf("ev wdata%0d", i), 128'(q_wd[i]), 128'(32'h11 * 32'(i + 1)));
        chk($sformatf("ev raddr%0d", i), 128'(q_addr[i+4]), 128'(32'h3000 + 32'(4 * i)));
        chk($sformatf("ev rwe%0d", i), 128'(q_we[i+4]), 0);
      end
    end
    chk("ev blk", mem_rd_blk, ABLK);
    chk("ev done_cnt", 128'(done_cnt), 1);

    // Eviction with ack every 3rd cycle.
    clear_log();
    issue(1, 1, 32'h0000_5550, 32'h0000_6004, 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001);
    wait_done("ws", 100, 3);
    cyc();
    chk("ws beats", 128'(q_addr.size()), 8);
    if (q_addr.size() == 8) begin
      chk("ws wd2", 128'(q_wd[2]), 128'(32'hDEAD0003));
      chk("ws wa3", 128'(q_addr[3]), 128'(32'h600C));
      chk("ws ra0", 128'(q_addr[4]), 128'(32'h5550));
    end
    chk("ws blk", mem_rd_blk, ABLK);
    chk("ws done_cnt", 128'(done_cnt), 1);

    // Write only, rd_en pulsed mid-burst must be ignored.
    clear_log();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    issue(1, 0, 32'h0000_1000, 32'h0, '0);
    wait_done("pre", 20, 1);
    cyc();
    clear_log();
    issue(0, 1, 32'h0, 32'h0000_4000, 128'h1);
    mem_rd_en = 1'b1; mem_rd_addr = 32'h0000_9000;
    cyc();
    mem_rd_en = 1'b0;
    wait_done("wo", 20, 1);
    cyc(); cyc(); cyc();
    chk("wo beats", 128'(q_addr.size()), 4);
    chk("wo last we", 128'(q_we[q_we.size()-1]), 1);
    chk("wo blk kept", mem_rd_blk, ABLK);
    chk("wo done_cnt", 128'(done_cnt), 1);
    chk("wo idle", 128'(mem_busy), 0);

    // Reset mid-burst after two read beats.
    clear_log();
    issue(1, 0, 32'h0000_1234, 32'h0, '0);
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("mr req", 128'(bus_req), 0);
    chk("mr busy", 128'(mem_busy), 0);
    chk("mr blk", mem_rd_blk, 0);
    cyc();
    rst_n = 1'b1;
    clear_log();
    issue(1, 0, 32'h0000_7774, 32'h0, '0);
    chk("mr restart addr", 128'(bus_addr), 128'(32'h7770));
    wait_done("mr", 20, 1);
    cyc();
    chk("mr beats", 128'(q_addr.size()), 4);
    chk("mr blk2", mem_rd_blk, ABLK);

    // Fill at word 2 of the block.
    clear_log();
    issue(1, 0, 32'h0000_1238, 32'h0, '0);
    cyc();
`ifdef CRITICAL_WORD_FIRST_EN
    chk("cw valid", 128'(crit_valid), 1);
    chk("cw word", 128'(crit_word), 128'(32'hA2));
`else
    chk("cw valid", 128'(crit_valid), 0);
    chk("cw word", 128'(crit_word), 0);
`endif
    wait_done("cw", 20, 1);
    cyc();
    chk("cw beats", 128'(q_addr.size()), 4);
    if (q_addr.size() == 4) begin
`ifdef CRITICAL_WORD_FIRST_EN
      chk("cw a0", 128'(q_addr[0]), 128'(32'h1238));
      chk("cw a1", 128'(q_addr[1]), 128'(32'h123C));
      chk("cw a2", 128'(q_addr[2]), 128'(32'h1230));
      chk("cw a3", 128'(q_addr[3]), 128'(32'h1234));
`else
      chk("cw a0", 128'(q_addr[0]), 128'(32'h1230));
      chk("cw a3", 128'(q_addr[3]), 128'(32'h123C));
`endif
    end
    chk("cw blk", mem_rd_blk, ABLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
